spi_reg_bank: RTL

Parametrised SPI mode-0 peripheral holding a bank of `NUM_REGS` configuration registers, each `DATA_W` bits wide, written and optionally read back over a 4-wire SPI link. It is the generalised successor of the fixed five-register, write-only SPI peripheral. It sits between the chip pins and the PWM/output-enable logic, and all logic runs in the system clock domain. It adds read-back on `cipo`, frame-error reporting and a write-commit strobe.

---
 rtl/spi_reg_bank.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 register bank with write commit, frame-error reporting and optional read-back (SPI_READBACK_EN)
module spi_reg_bank #(
  parameter int                NUM_REGS = 5,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         cs,
  input  logic                         copi,
  output logic                         cipo,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic                         wr_pulse,
  output logic [6:0]                   wr_addr,
  output logic                         frame_err
);
  localparam int FRAME_LEN = 8 + DATA_W;
  localparam int CW = $clog2(FRAME_LEN + 1);
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state, state_n;
  logic [2:0] sclk_s, cs_s;
  logic [1:0] copi_s;
  logic sclk_rise, cs_rise, cs_fall, bit_in;
  logic [CW-1:0] cnt;
  logic [7:0] cmd, cmd_n;
  logic [DATA_W-1:0] data, data_n;
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic start, shift_cmd, shift_data, commit, reject, addr_ok;
  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign cs_rise = cs_s[1] & ~cs_s[2];
  assign cs_fall = cs_s[2] & ~cs_s[1];
  assign bit_in = copi_s[1];
  assign cmd_n = 8'({cmd, bit_in});
  assign data_n = DATA_W'({data, bit_in});
  assign addr_ok = {1'b0, cmd[6:0]} < 8'(NUM_REGS);
  // Synchronise the pins; cs idles high so reset must not look like a cs fall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s <= 3'b000;
      cs_s <= 3'b111;
      copi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      cs_s <= {cs_s[1:0], cs};
      copi_s <= {copi_s[0], copi};
    end
  end
  // Frame state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  // Frame sequencing: cs edges take priority over sclk edges
  always_comb begin
    state_n = state;
    start = 1'b0;
    shift_cmd = 1'b0;
    shift_data = 1'b0;
    commit = 1'b0;
    reject = 1'b0;
    if (cs_fall) begin
      state_n = CMD;
      start = 1'b1;
    end else if (cs_rise && (state == CMD || state == DATA)) begin
      state_n = IDLE;
      reject = 1'b1;
    end else if (cs_rise && state == DONE) begin
      state_n = IDLE;
    end else if (sclk_rise && state == CMD) begin
      shift_cmd = 1'b1;
      state_n = (cnt == CW'(7)) ? DATA : CMD;
    end else if (sclk_rise && state == DATA) begin
      shift_data = 1'b1;
      if (cnt == CW'(FRAME_LEN - 1)) begin
        state_n = DONE;
        commit = cmd[7] & addr_ok;
        reject = ~addr_ok;
      end
    end
  end
  // Receive shifting, bit count and the commit/error strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      cmd <= '0;
      data <= '0;
      wr_pulse <= 1'b0;
      frame_err <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_pulse <= commit;
      frame_err <= reject;
      if (start) begin
        cnt <= '0;
        cmd <= '0;
        data <= '0;
      end
      if (shift_cmd) begin
        cmd <= cmd_n;
        cnt <= cnt + CW'(1);
      end
      if (shift_data) begin
        data <= data_n;
        cnt <= cnt + CW'(1);
      end
      if (commit) wr_addr <= cmd[6:0];
    end
  end
  // Register storage; the final data bit is merged in on the commit cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (commit && cmd[6:0] == 7'(i)) mem[i] <= data_n;
    end
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs[g*DATA_W +: DATA_W] = mem[g];
  end
`ifdef SPI_READBACK_EN
  logic sclk_fall;
  logic [DATA_W-1:0] tx, tx_ld;
  assign sclk_fall = sclk_s[2] & ~sclk_s[1];
  assign cipo = tx[DATA_W-1];
  // Select the addressed register for a read; writes and bad addresses shift out zeros
  always_comb begin
    tx_ld = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (!cmd_n[7] && cmd_n[6:0] == 7'(i)) tx_ld = mem[i];
  end
  // Transmit shifter: MSB appears after the 8th rise, the fall right after it is skipped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx <= '0;
    else if (start || state_n == IDLE) tx <= '0;
    else if (shift_cmd && cnt == CW'(7)) tx <= tx_ld;
    else if (sclk_fall && state == DATA && cnt != CW'(8)) tx <= tx << 1;
  end
`else
  assign cipo = 1'b0;
`endif
endmodule
